mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares a single backing memory port between instruction fetch and the data-memory stage of the five-stage RISC-V pipeline. Accepts one outstanding transaction at a time, drives the memory-side request/acknowledge handshake, and returns read data and a completion pulse to the owning requester. Data accesses have priority over fetch, subject to a starvation limit that guarantees fetch forward progress.

## Interface
- MAX_D_STREAK, 4: consecutive data grants allowed while fetch is waiting before fetch is forced to win.
- TIMEOUT, 255: cycles spent in BUSY without `m_ack` before a transaction is aborted (only with `MEM_ARB_TIMEOUT_EN`).
- clock  in  1  the only clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request; held with `f_addr` stable until `f_gnt`.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  one-cycle pulse: fetch request accepted.
- f_valid  out  1  one-cycle pulse: fetch complete, `f_rdata` valid.
- f_rdata  out  32  fetch read data.
- d_req  in  1  data request; fields held stable until `d_gnt`.
- d_rw  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_size  in  2  access size: 0 byte, 1 half, 2 word.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_valid  out  1  one-cycle pulse: data access complete; `d_rdata` valid on reads, 0 on writes.
- d_rdata  out  32  data read data.
- m_req  out  1  memory request; held high until `m_ack` is sampled.
- m_rw, m_addr, m_wdata, m_size  out  1/32/32/2  registered copy of the granted request; fetch drives rw=0, size=2, wdata=0.
- m_ack  in  1  memory completion; sampled only in BUSY.
- m_rdata  in  32  memory read data, valid with `m_ack`.
- err  out  1  one-cycle pulse with `*_valid`: transaction timed out.

## Operation
- States: IDLE, BUSY, RESP.
- Arbitration happens at every edge in IDLE or RESP:
  - If neither request is high, go to (or stay in) IDLE.
  - If only one request is high, grant it.
  - If both are high, grant data, unless `streak == MAX_D_STREAK`; then grant fetch.
- On grant: latch the owner and the request fields into the `m_*` registers, assert `m_req`, pulse the owner's `*_gnt`, and move to BUSY.
- Streak counter ($clog2(MAX_D_STREAK+1) bits):
  - +1 on a data grant made while `f_req` was high.
  - Cleared on any fetch grant.
  - Unchanged on a data grant made while `f_req` was low.
  - Saturates at MAX_D_STREAK.
- BUSY with `m_ack`=1 at an edge: capture `m_rdata` (0 for writes), drop `m_req`, move to RESP, and pulse the owner's `*_valid` with the data.
- The requester that was not granted keeps its request high; it is arbitrated again in RESP. Back-to-back transactions need no IDLE cycle.
- A request dropped before its `*_gnt` is legal and leaves no side effect.
- `m_ack` in IDLE/RESP is ignored.
- Reset (asynchronous, `reset`=0): state IDLE, streak 0, timeout counter 0. All outputs go to 0 immediately, including `m_req` mid-transaction; an in-flight transaction is discarded with no valid pulse.

## Timing
- Request sampled at edge N → `*_gnt` and `m_req` high during cycle N+1.
- `m_ack` sampled at edge N+k (k≥1) → `*_valid`/`*_rdata`/`err` high during cycle N+k+1 only.
- Minimum turnaround is 2 cycles from grant edge to completion pulse; a new grant can issue at the same edge that enters RESP+1.
- Peak throughput is one transaction per 2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A timeout counter increments each BUSY cycle and clears on entry to BUSY.
  - When it reaches TIMEOUT with no `m_ack`: drop `m_req`, go to RESP, pulse the owner's `*_valid` with `*_rdata`=0 and `err`=1.
  - An `m_ack` arriving on the timeout edge wins (normal completion, `err`=0).
- Not defined: no counter; BUSY waits indefinitely; `err` is tied 0.

## Test plan
- Only `f_req`, `f_addr`=0x01000000, memory acks 1 cycle after `m_req` with 0x00000013 → `f_gnt` in cycle 1; `m_addr`=0x01000000, `m_rw`=0, `m_size`=2; `f_valid` with `f_rdata`=0x00000013 in cycle 3.
- Both requesting in the same cycle, data write to 0x01000100 with `d_wdata`=0xDEADBEEF, `d_size`=0 → `d_gnt` first, `m_rw`=1, `m_wdata`=0xDEADBEEF; `d_valid` with `d_rdata`=0; `f_gnt` at the RESP edge.
- `f_req` and `d_req` held high continuously for 12 transactions → grant order D,D,D,D,F,D,D,D,D,F,…; streak never exceeds 4.
- `reset` asserted while BUSY (before `m_ack`) → `m_req`, `*_gnt`, `*_valid` all 0 immediately; no valid pulse after release; first grant occurs one edge after release.
- With `MEM_ARB_TIMEOUT_EN`, TIMEOUT=8, `m_ack` never asserted → `m_req` drops after 8 BUSY cycles; `d_valid`=1, `err`=1, `d_rdata`=0 in the same cycle. Without the macro, `m_req` stays high for 1000 cycles and `err` stays 0.
- `m_ack` pulsed in IDLE with no request → no state change, no valid pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the shared memory port: one outstanding access.
// Build option: MEM_ARB_TIMEOUT_EN adds an abort counter for stuck BUSY.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_rw,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_size,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        err
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic        own_d_q, own_d_d;
  logic        f_gnt_q, f_gnt_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic        d_gnt_q, d_gnt_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        m_req_q, m_req_d;
  logic        m_rw_q, m_rw_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [1:0]  m_size_q, m_size_d;
  logic        err_q, err_d;
  logic        pick_d, pick_f;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Data wins unless fetch has waited through a full data streak.
  assign pick_d = d_req & ~(f_req & (streak_q == SMAX));
  assign pick_f = f_req & ~pick_d;

  // Next state: arbitration, memory handshake and completion pulses.
  always_comb begin
    state_d   = state_q;
    streak_d  = streak_q;
    own_d_d   = own_d_q;
    m_req_d   = m_req_q;
    m_rw_d    = m_rw_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_size_d  = m_size_q;
    f_gnt_d   = 1'b0;
    f_valid_d = 1'b0;
    f_rdata_d = '0;
    d_gnt_d   = 1'b0;
    d_valid_d = 1'b0;
    d_rdata_d = '0;
    err_d     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        unique case (1'b1)
          pick_d: begin
            state_d   = S_BUSY;
            own_d_d   = 1'b1;
            d_gnt_d   = 1'b1;
            m_req_d   = 1'b1;
            m_rw_d    = d_rw;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_size_d  = d_size;
            if (f_req && streak_q != SMAX)
              streak_d = streak_q + 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_d     = '0;
`endif
          end
          pick_f: begin
            state_d   = S_BUSY;
            own_d_d   = 1'b0;
            f_gnt_d   = 1'b1;
            m_req_d   = 1'b1;
            m_rw_d    = 1'b0;
            m_addr_d  = f_addr;
            m_wdata_d = '0;
            m_size_d  = 2'd2;
            streak_d  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_d     = '0;
`endif
          end
          default: ;
        endcase
      end
      S_BUSY: begin
        if (m_ack) begin
          state_d = S_RESP;
          m_req_d = 1'b0;
          if (own_d_q) begin
            d_valid_d = 1'b1;
            d_rdata_d = m_rw_q ? '0 : m_rdata;
          end else begin
            f_valid_d = 1'b1;
            f_rdata_d = m_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (tmo_q == TLAST) begin
          state_d   = S_RESP;
          m_req_d   = 1'b0;
          err_d     = 1'b1;
          d_valid_d = own_d_q;
          f_valid_d = ~own_d_q;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset drops everything at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      streak_q  <= '0;
      own_d_q   <= 1'b0;
      f_gnt_q   <= 1'b0;
      f_valid_q <= 1'b0;
      f_rdata_q <= '0;
      d_gnt_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_rdata_q <= '0;
      m_req_q   <= 1'b0;
      m_rw_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_size_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      own_d_q   <= own_d_d;
      f_gnt_q   <= f_gnt_d;
      f_valid_q <= f_valid_d;
      f_rdata_q <= f_rdata_d;
      d_gnt_q   <= d_gnt_d;
      d_valid_q <= d_valid_d;
      d_rdata_q <= d_rdata_d;
      m_req_q   <= m_req_d;
      m_rw_q    <= m_rw_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_size_q  <= m_size_d;
      err_q     <= err_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Cycles spent waiting for the memory in the current access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      tmo_q <= '0;
    else
      tmo_q <= tmo_d;
  end
`endif

  assign f_gnt   = f_gnt_q;
  assign f_valid = f_valid_q;
  assign f_rdata = f_rdata_q;
  assign d_gnt   = d_gnt_q;
  assign d_valid = d_valid_q;
  assign d_rdata = d_rdata_q;
  assign m_req   = m_req_q;
  assign m_rw    = m_rw_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_size  = m_size_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model plus directed vectors.
// Memory returns addr ^ 0x01000013 as read data.
module tb_mem_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_gnt, f_valid;
  logic [31:0] f_rdata;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = '0;
  logic        d_gnt, d_valid;
  logic [31:0] d_rdata;
  logic        m_req, m_rw;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_size;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr),
    .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_size(d_size),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_size(m_size),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h0100_0013;
  endfunction

  // Memory responder: ack after lat cycles of m_req.
  logic ack_r = 1'b0;
  logic force_ack = 1'b0;
  bit   resp_en = 1'b0;
  int   lat = 1;
  int   wcnt = 0;
  assign m_ack   = ack_r | force_ack;
  assign m_rdata = m_ack ? mem(m_addr) : 32'h0;

  always @(negedge clock) begin
    if (resp_en && m_req && !ack_r) begin
      if (wcnt >= lat) begin
        ack_r = 1'b1;
        wcnt  = 0;
      end else begin
        wcnt++;
      end
    end else begin
      ack_r = 1'b0;
      wcnt  = 0;
    end
  end

  // Model: one access in flight, data first unless fetch starved.
  bit          busy = 0;
  bit          own_d = 0;
  int          streak = 0;
  int          tmo = 0;
  logic        e_fg = 0, e_fv = 0, e_dg = 0, e_dv = 0;
  logic        e_mreq = 0, e_mrw = 0, e_err = 0;
  logic [31:0] e_fr = 0, e_dr = 0, e_ma = 0, e_mw = 0;
  logic [1:0]  e_ms = 0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy = 0; own_d = 0; streak = 0; tmo = 0;
      e_fg = 0; e_fv = 0; e_dg = 0; e_dv = 0;
      e_mreq = 0; e_mrw = 0; e_err = 0;
      e_fr = 0; e_dr = 0; e_ma = 0; e_mw = 0; e_ms = 0;
    end else begin
      e_fg = 0; e_fv = 0; e_dg = 0; e_dv = 0;
      e_fr = 0; e_dr = 0; e_err = 0;
      if (!busy) begin
        if (d_req && !(f_req && streak == MAXS)) begin
          if (f_req && streak < MAXS) streak++;
          own_d = 1; e_dg = 1; busy = 1; e_mreq = 1; tmo = 0;
          e_mrw = d_rw; e_ma = d_addr; e_mw = d_wdata; e_ms = d_size;
        end else if (f_req) begin
          streak = 0;
          own_d = 0; e_fg = 1; busy = 1; e_mreq = 1; tmo = 0;
          e_mrw = 0; e_ma = f_addr; e_mw = 0; e_ms = 2'd2;
        end
      end else if (m_ack) begin
        busy = 0; e_mreq = 0;
        if (own_d) begin
          e_dv = 1;
          e_dr = e_mrw ? 32'h0 : mem(e_ma);
        end else begin
          e_fv = 1;
          e_fr = mem(e_ma);
        end
      end else begin
`ifdef MEM_ARB_TIMEOUT_EN
        tmo++;
        if (tmo == TMO) begin
          busy = 0; e_mreq = 0; e_err = 1;
          if (own_d) e_dv = 1;
          else e_fv = 1;
        end
`endif
      end
    end
  end

  // Every cycle: full output vector against the model.
  always @(negedge clock) begin
    n_chk++;
    if ({f_gnt, f_valid, f_rdata, d_gnt, d_valid, d_rdata,
         m_req, m_rw, m_addr, m_wdata, m_size, err} !==
        {e_fg, e_fv, e_fr, e_dg, e_dv, e_dr,
         e_mreq, e_mrw, e_ma, e_mw, e_ms, e_err}) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t got fg%b fv%b fr%h dg%b dv%b dr%h mq%b rw%b a%h w%h s%0d e%b want fg%b fv%b fr%h dg%b dv%b dr%h mq%b rw%b a%h w%h s%0d e%b",
               $time, f_gnt, f_valid, f_rdata, d_gnt, d_valid, d_rdata,
               m_req, m_rw, m_addr, m_wdata, m_size, err,
               e_fg, e_fv, e_fr, e_dg, e_dv, e_dr,
               e_mreq, e_mrw, e_ma, e_mw, e_ms, e_err);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  string got;
  int    g;
  int    budget;
  int    hi;

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_m_req", m_req, 0);
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_d_valid", d_valid, 0);
    reset = 1'b1;
    resp_en = 1; lat = 1;
    @(negedge clock);

    // Lone fetch
    f_req = 1; f_addr = 32'h0100_0000;
    @(negedge clock);
    chk("t1_f_gnt", f_gnt, 1);
    chk("t1_m_addr", m_addr, 32'h0100_0000);
    chk("t1_m_rw", m_rw, 0);
    chk("t1_m_size", m_size, 2);
    f_req = 0;
    repeat (2) @(negedge clock);
    chk("t1_f_valid", f_valid, 1);
    chk("t1_f_rdata", f_rdata, 32'h0000_0013);
    @(negedge clock);

    // Simultaneous data write and fetch
    d_req = 1; d_rw = 1; d_addr = 32'h0100_0100;
    d_wdata = 32'hDEAD_BEEF; d_size = 0;
    f_req = 1; f_addr = 32'h0100_0004;
    @(negedge clock);
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_f_gnt0", f_gnt, 0);
    chk("t2_m_rw", m_rw, 1);
    chk("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("t2_m_size", m_size, 0);
    d_req = 0;
    repeat (2) @(negedge clock);
    chk("t2_d_valid", d_valid, 1);
    chk("t2_d_rdata", d_rdata, 0);
    @(negedge clock);
    chk("t2_f_gnt", f_gnt, 1);
    chk("t2_f_addr", m_addr, 32'h0100_0004);
    f_req = 0;
    repeat (2) @(negedge clock);
    chk("t2_f_rdata", f_rdata, 32'h0000_0017);
    @(negedge clock);

    // Both held high: starvation limit
    lat = 0; d_rw = 0; d_addr = 32'h40; d_size = 2;
    f_req = 1; d_req = 1;
    got = ""; g = 0; budget = 0;
    while (g < 12 && budget < 200) begin
      @(negedge clock);
      budget++;
      if (d_gnt) begin got = {got, "D"}; g++; end
      else if (f_gnt) begin got = {got, "F"}; g++; end
    end
    f_req = 0; d_req = 0;
    n_chk++;
    if (got != "DDDDFDDDDFDD") begin
      n_err++;
      $display("FAIL t3_order: got %s expected DDDDFDDDDFDD", got);
    end
    repeat (4) @(negedge clock);

    // Reset during BUSY
    resp_en = 0; d_req = 1; d_rw = 0; d_addr = 32'h200;
    @(negedge clock);
    chk("t4_d_gnt", d_gnt, 1);
    @(negedge clock);
    chk("t4_busy_m_req", m_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("t4_rst_m_req", m_req, 0);
    chk("t4_rst_d_gnt", d_gnt, 0);
    chk("t4_rst_d_valid", d_valid, 0);
    chk("t4_rst_m_addr", m_addr, 0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    resp_en = 1; lat = 1;
    @(negedge clock);
    chk("t4_first_gnt", d_gnt, 1);
    d_req = 0;
    repeat (4) @(negedge clock);

    // Stuck memory
    resp_en = 0; d_req = 1; d_rw = 1; d_addr = 32'h300;
    d_wdata = 32'h1234_5678; d_size = 1;
    @(negedge clock);
    chk("t5_d_gnt", d_gnt, 1);
    d_req = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    hi = 1; budget = 0;
    while (budget < 20) begin
      @(negedge clock);
      budget++;
      if (m_req) hi++;
      else break;
    end
    chk("t5_busy_cycles", hi, TMO);
    chk("t5_d_valid", d_valid, 1);
    chk("t5_err", err, 1);
    chk("t5_d_rdata", d_rdata, 0);
`else
    repeat (1000) @(negedge clock);
    chk("t5_m_req_held", m_req, 1);
    chk("t5_err0", err, 0);
    resp_en = 1;
    budget = 0;
    while (!d_valid && budget < 10) begin
      @(negedge clock);
      budget++;
    end
    chk("t5_late_done", d_valid, 1);
`endif
    repeat (3) @(negedge clock);

    // Spurious ack while idle
    force_ack = 1;
    @(negedge clock);
    force_ack = 0;
    @(negedge clock);
    chk("t6_f_valid", f_valid, 0);
    chk("t6_d_valid", d_valid, 0);
    chk("t6_m_req", m_req, 0);
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
